mem_resp_ctrl: RTL and testbench
================================

Name: mem_resp_ctrl

Overview:
- Memory-side responder for the pipeline's toggle-based memory request interface.
- The MEM stage flips `req_toggle_i` once per load/store. It holds `req_op_i`, `req_addr_i` and `req_wdata_i` stable until the response toggle flips.
- This block sequences the access as little-endian byte transfers over the 8-bit unified RAM port. It returns load data (sign- or zero-extended) and answers by flipping `rsp_toggle_o`.

Parameters:
- ADDR_W, 32, width of RAM byte address (`ram_addr_o`).
- RD_LAT, 1, cycles from `ram_addr_o` (read) to valid `ram_din_i`; legal values 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_toggle_i  in  1  request toggle; a new request is pending when it differs from the internal seen-flag.
- req_op_i  in  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes are treated as NOP.
- req_addr_i  in  32  byte address; low ADDR_W bits used.
- req_wdata_i  in  32  store data; low bytes used for SB/SH.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wr_o  out  1  1 = write `ram_dout_o` at `ram_addr_o` this cycle; 0 = read.
- ram_dout_o  out  8  write byte.
- ram_din_i  in  8  read byte, valid RD_LAT cycles after its address.
- rsp_toggle_o  out  1  flips once per completed request.
- rsp_rdata_o  out  32  load result; valid from the rsp_toggle_o flip until the next flip.
- rsp_err_o  out  1  error flag of the current response (see Optional Feature).
- busy_o  out  1  1 in any state other than IDLE.

Behaviour:
- Reset values:
  - `ram_addr_o`, `ram_dout_o`, `rsp_rdata_o` = 0.
  - `ram_wr_o`, `rsp_toggle_o`, `rsp_err_o`, `busy_o` = 0.
  - Seen-flag = 0; state = IDLE.
- Reset mid-operation aborts the access with no response flip. `ram_wr_o` is 0 from the first cycle after the reset edge.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - If `req_toggle_i` != seen: latch op/addr/wdata, seen <= `req_toggle_i` (cycle T = accept cycle).
  - N = 1 (B/BU/SB), 2 (H/HU/SH), 4 (W/SW).
  - NOP/invalid op goes to RESP; all others go to ISSUE with k = 0.
  - While idle: `ram_wr_o` = 0, `ram_addr_o` holds its last value.
- ISSUE (cycles T+1 .. T+N):
  - `ram_addr_o` = addr + k (wraps modulo 2^ADDR_W).
  - Store: `ram_wr_o` = 1, `ram_dout_o` = wdata[8k+7:8k].
  - Load: `ram_wr_o` = 0.
  - k increments each cycle. After k = N-1, a store goes to RESP and a load goes to DRAIN.
- Load byte capture:
  - Byte k is captured from `ram_din_i` in cycle T+1+k+RD_LAT into assembly slot k.
  - Issue is pipelined; one address per cycle, no bubbles.
- DRAIN: wait until the last byte is captured (cycle T+N+RD_LAT), then go to RESP.
- RESP (one cycle):
  - `rsp_toggle_o` flips at the end of this cycle.
  - `rsp_rdata_o` updates at the same edge as the flip:
    - LB/LH: sign-extend from bit 7/15.
    - LBU/LHU: zero-extend.
    - LW: raw word.
    - Stores and NOP: `rsp_rdata_o` unchanged.
  - Then go to IDLE.
- Latency from accept cycle T to visible flip:
  - Store: T+N+2.
  - Load: T+N+RD_LAT+2.
  - NOP: T+2.
- Back-to-back: a toggle already pending when IDLE is re-entered is accepted in that first IDLE cycle.
- Protocol rules:
  - Toggle changes while `busy_o` = 1 are not observed until IDLE. The requester must wait for `rsp_toggle_o` to equal its request toggle before issuing again.
  - Input changes during busy do not affect the latched request.
- No alignment restriction by default; each byte goes to consecutive addresses.

Optional Feature:
- MEMCTRL_ALIGN_CHK_EN.
- Defined:
  - An accepted LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0, skips ISSUE/DRAIN and goes directly to RESP.
  - No RAM write occurs; `rsp_rdata_o` is unchanged.
  - `rsp_err_o` = 1 is registered with the flip; every other response registers `rsp_err_o` = 0.
- Undefined: `rsp_err_o` is tied 0 and misaligned accesses proceed byte-wise as normal.

Test Plan:
- Reset, then hold idle 5 cycles -> all outputs 0, `busy_o` = 0, no RAM write.
- SW addr 0x100, wdata 0xDEADBEEF -> writes 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 in consecutive cycles; `rsp_toggle_o` flips at T+6.
- LB and LBU at 0x103 after the SW, RD_LAT = 1 -> `rsp_rdata_o` = 0xFFFFFFDE then 0x000000DE; each flip at T+4.
- LH addr 0x101 (misaligned, feature off) -> 0xFFFFADBE. With MEMCTRL_ALIGN_CHK_EN -> no RAM activity, `rsp_err_o` = 1, flip at T+2.
- Issue an SH while idle and re-toggle the request immediately upon its response -> the second request is accepted in the first IDLE cycle; exactly two flips total.
- Assert rst during the ISSUE cycle with k = 1 of an SW -> no further writes after the reset edge, `rsp_toggle_o` stays 0, the block is accepted as idle afterwards.

Source files
------------

// File: rtl/mem_resp_ctrl.sv
// Toggle-handshake memory responder: sequences loads/stores as little-endian byte
// transfers on an 8-bit RAM port. Optional build macro: MEMCTRL_ALIGN_CHK_EN.
module mem_resp_ctrl #(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_toggle_i,
   input  logic [3:0]        req_op_i,
   input  logic [31:0]       req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   output logic              rsp_toggle_o,
   output logic [31:0]       rsp_rdata_o,
   output logic              rsp_err_o,
   output logic              busy_o
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
   localparam logic [2:0] LAT3   = 3'(RD_LAT);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

   function automatic logic [2:0] op_len(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_len = 3'd1;
         OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
         OP_LW, OP_SW:         op_len = 3'd4;
         default:              op_len = 3'd0;
      endcase
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_load(input logic [3:0] op);
      is_load = (op >= OP_LB) && (op <= OP_LHU);
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_of = w[7:0];
         2'd1:    byte_of = w[15:8];
         2'd2:    byte_of = w[23:16];
         default: byte_of = w[31:24];
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [31:0] raw);
      case (op)
         OP_LB:   load_extend = {{24{raw[7]}}, raw[7:0]};
         OP_LH:   load_extend = {{16{raw[15]}}, raw[15:0]};
         OP_LBU:  load_extend = {24'd0, raw[7:0]};
         OP_LHU:  load_extend = {16'd0, raw[15:0]};
         default: load_extend = raw;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic                seen_q, seen_d;
   logic [3:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [2:0]          cnt_q, cnt_d, cnt_next;
   logic [7:0]          rdbuf_q [4];
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic                ram_wr_q, ram_wr_d;
   logic [7:0]          ram_dout_q, ram_dout_d;
   logic                rsp_toggle_q, rsp_toggle_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic [2:0]          len_q;
   logic [2:0]          cap_idx;
   logic                cap_en;
   logic                accept;
   logic                misal_now;
   logic                acc_bad;

   assign accept = (state_q == IDLE) && (req_toggle_i != seen_q);
   assign len_q  = op_len(op_q);

`ifdef MEMCTRL_ALIGN_CHK_EN
   function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
      case (op_len(op))
         3'd2:    misaligned = a[0];
         3'd4:    misaligned = (a != 2'b00);
         default: misaligned = 1'b0;
      endcase
   endfunction

   logic bad_q;
   logic rsp_err_q;

   assign misal_now = misaligned(req_op_i, req_addr_i[1:0]);
   assign acc_bad   = bad_q;

   // Misalignment is decided once at accept and reported with that request's flip.
   always_ff @(posedge clk) begin
      if (rst) begin
         bad_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         if (accept) bad_q <= misal_now;
         if (state_q == RESP) rsp_err_q <= bad_q;
      end
   end

   assign rsp_err_o = rsp_err_q;
`else
   assign misal_now = 1'b0;
   assign acc_bad   = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

   // Byte k of a load returns RD_LAT cycles after its address, counted from the first ISSUE cycle.
   assign cap_idx = cnt_q - LAT3;
   assign cap_en  = ((state_q == ISSUE) || (state_q == DRAIN)) && is_load(op_q)
                    && (cnt_q >= LAT3) && (cap_idx < len_q);

   always_comb begin
      state_d      = state_q;
      seen_d       = seen_q;
      op_d         = op_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      cnt_next     = cnt_q + 3'd1;
      ram_addr_d   = ram_addr_q;
      ram_wr_d     = 1'b0;
      ram_dout_d   = ram_dout_q;
      rsp_toggle_d = rsp_toggle_q;
      rsp_rdata_d  = rsp_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               seen_d  = req_toggle_i;
               op_d    = req_op_i;
               addr_d  = req_addr_i[ADDR_W-1:0];
               wdata_d = req_wdata_i;
               cnt_d   = 3'd0;
               if ((op_len(req_op_i) == 3'd0) || misal_now) begin
                  state_d = RESP;
               end else begin
                  state_d    = ISSUE;
                  ram_addr_d = req_addr_i[ADDR_W-1:0];
                  ram_wr_d   = is_store(req_op_i);
                  ram_dout_d = req_wdata_i[7:0];
               end
            end
         end
         ISSUE: begin
            cnt_d = cnt_next;
            if (cnt_q == len_q - 3'd1) begin
               state_d = is_store(op_q) ? RESP : DRAIN;
            end else begin
               ram_addr_d = addr_q + ADDR_W'(cnt_next);
               ram_wr_d   = is_store(op_q);
               ram_dout_d = byte_of(wdata_q, cnt_next[1:0]);
            end
         end
         DRAIN: begin
            cnt_d = cnt_next;
            if (cnt_q == len_q - 3'd1 + LAT3) state_d = RESP;
         end
         RESP: begin
            rsp_toggle_d = ~rsp_toggle_q;
            if (is_load(op_q) && !acc_bad)
               rsp_rdata_d = load_extend(op_q, {rdbuf_q[3], rdbuf_q[2], rdbuf_q[1], rdbuf_q[0]});
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         seen_q       <= 1'b0;
         cnt_q        <= 3'd0;
         ram_addr_q   <= '0;
         ram_wr_q     <= 1'b0;
         ram_dout_q   <= 8'd0;
         rsp_toggle_q <= 1'b0;
         rsp_rdata_q  <= 32'd0;
      end else begin
         state_q      <= state_d;
         seen_q       <= seen_d;
         cnt_q        <= cnt_d;
         ram_addr_q   <= ram_addr_d;
         ram_wr_q     <= ram_wr_d;
         ram_dout_q   <= ram_dout_d;
         rsp_toggle_q <= rsp_toggle_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   // Request payload and read assembly carry no reset; they are only consumed after an accept.
   always_ff @(posedge clk) begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (cap_en) rdbuf_q[cap_idx[1:0]] <= ram_din_i;
   end

   assign ram_addr_o   = ram_addr_q;
   assign ram_wr_o     = ram_wr_q;
   assign ram_dout_o   = ram_dout_q;
   assign rsp_toggle_o = rsp_toggle_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: directed table, back-to-back and reset-abort
// sequences, then random requests against a byte-array reference model.
module tb_mem_resp_ctrl;

   localparam int RD_LAT = 1;
   localparam int MEMSZ  = 1024;

   logic        clk;
   logic        rst;
   logic        req_tog;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        rsp_toggle;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   mem_resp_ctrl #(.ADDR_W(32), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_toggle_i(req_tog), .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout), .ram_din_i(ram_din),
      .rsp_toggle_o(rsp_toggle), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .busy_o(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Environment RAM with RD_LAT-cycle read pipeline, plus a fill port for initial contents.
   logic [7:0] mem [MEMSZ];
   logic [7:0] rdp [RD_LAT];
   logic       fill_en;
   logic [9:0] fill_idx;
   logic [7:0] fill_val;
   int         cyc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fill_en) mem[fill_idx] <= fill_val;
      else if (ram_wr) mem[ram_addr[9:0]] <= ram_dout;
      rdp[0] <= mem[ram_addr[9:0]];
      for (int i = 1; i < RD_LAT; i++) rdp[i] <= rdp[i-1];
   end
   assign ram_din = rdp[RD_LAT-1];

   typedef struct { logic [31:0] a; logic [7:0] d; int c; } wr_t;
   wr_t  wlog [$];
   int   flips = 0;
   logic tog_seen = 1'b0;

   always @(negedge clk) begin
      if (ram_wr === 1'b1) wlog.push_back('{ram_addr, ram_dout, cyc});
      if (rsp_toggle !== tog_seen) begin
         flips    = flips + 1;
         tog_seen = rsp_toggle;
      end
   end

   // Reference model state
   logic [7:0]  ref_mem [MEMSZ];
   logic [31:0] ref_rd;
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic int op_bytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit model_misal(input int n, input logic [31:0] addr);
`ifdef MEMCTRL_ALIGN_CHK_EN
      return (addr % n) != 0 && n > 1;
`else
      return (n < 0) && (addr == 0);
`endif
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
      logic [63:0] v;
      logic [31:0] a;
      int n;
      n = op_bytes(op);
      v = 0;
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         v = v + (64'(ref_mem[a[9:0]]) << (8 * i));
      end
      if ((op == 4'd1 || op == 4'd2) && v >= (64'd1 << (8 * n - 1)))
         v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   // Issue one request (caller is #1 after a rising edge) and wait, bounded, for the response flip.
   task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output int t0, output int wbase);
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      req_tog   = ~req_tog;
      t0        = cyc;
      wbase     = wlog.size();
      lat       = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (rsp_toggle !== req_tog && lat < 60);
   endtask

   task automatic run_req(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
      int n, elat, t0, wbase, nw;
      bit st, ld, mis;
      logic [31:0] a;
      n   = op_bytes(op);
      st  = (op >= 4'd6 && op <= 4'd8);
      ld  = (op >= 4'd1 && op <= 4'd5);
      mis = model_misal(n, addr);
      if (ld && !mis) ref_rd = ref_load(op, addr);
      elat = (n == 0 || mis) ? 2 : (st ? n + 2 : n + RD_LAT + 2);
      do_req(op, addr, wd, lat, t0, wbase);
      chk({nm, "_lat"}, lat, elat);
      chk({nm, "_rdata"}, rsp_rdata, ref_rd);
      chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, mis});
      nw = (st && !mis) ? n : 0;
      chk({nm, "_nwr"}, wlog.size() - wbase, nw);
      for (int i = 0; i < nw; i++) begin
         a = addr + 32'(i);
         if (wbase + i < wlog.size()) begin
            chk({nm, "_wa"}, wlog[wbase+i].a, a);
            chk({nm, "_wd"}, {24'd0, wlog[wbase+i].d}, {24'd0, wd[8*i +: 8]});
            chk({nm, "_wc"}, wlog[wbase+i].c, t0 + 1 + i);
         end
         ref_mem[a[9:0]] = wd[8*i +: 8];
      end
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          lat;
      logic        err;
   } vec_t;
   vec_t tbl [14];

   initial begin
      int lat, t0, wbase, f0, f1;
      logic [3:0]  rop;
      logic [31:0] raddr;

      tbl[0]  = '{4'd8,  32'h100, 32'hDEADBEEF, 32'h00000000, 6, 1'b0};
      tbl[1]  = '{4'd1,  32'h103, 32'h0,        32'hFFFFFFDE, 4, 1'b0};
      tbl[2]  = '{4'd4,  32'h103, 32'h0,        32'h000000DE, 4, 1'b0};
      tbl[3]  = '{4'd2,  32'h101, 32'h0,        32'hFFFFADBE, 5, 1'b0};
      tbl[4]  = '{4'd3,  32'h100, 32'h0,        32'hDEADBEEF, 7, 1'b0};
      tbl[5]  = '{4'd5,  32'h102, 32'h0,        32'h0000DEAD, 5, 1'b0};
      tbl[6]  = '{4'd0,  32'h0,   32'h0,        32'h0000DEAD, 2, 1'b0};
      tbl[7]  = '{4'd7,  32'h200, 32'h12348001, 32'h0000DEAD, 4, 1'b0};
      tbl[8]  = '{4'd2,  32'h200, 32'h0,        32'hFFFF8001, 5, 1'b0};
      tbl[9]  = '{4'd12, 32'h0,   32'h0,        32'hFFFF8001, 2, 1'b0};
      tbl[10] = '{4'd6,  32'h201, 32'h0000007F, 32'hFFFF8001, 3, 1'b0};
      tbl[11] = '{4'd5,  32'h200, 32'h0,        32'h00007F01, 5, 1'b0};
      tbl[12] = '{4'd8,  32'h102, 32'hCAFEF00D, 32'h00007F01, 6, 1'b0};
      tbl[13] = '{4'd3,  32'h100, 32'h0,        32'hF00DBEEF, 7, 1'b0};
`ifdef MEMCTRL_ALIGN_CHK_EN
      tbl[3]  = '{4'd2,  32'h101, 32'h0,        32'h000000DE, 2, 1'b1};
      tbl[12] = '{4'd8,  32'h102, 32'hCAFEF00D, 32'h00007F01, 2, 1'b1};
      tbl[13] = '{4'd3,  32'h100, 32'h0,        32'hDEADBEEF, 7, 1'b0};
`endif

      rst = 1'b1; req_tog = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
      fill_en = 1'b0; fill_idx = 10'd0; fill_val = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rst_rsp_toggle", {31'd0, rsp_toggle}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_no_writes", wlog.size(), 0);

      for (int i = 0; i < MEMSZ; i++) begin
         fill_en  = 1'b1;
         fill_idx = 10'(i);
         fill_val = 8'($urandom);
         ref_mem[i] = fill_val;
         @(posedge clk);
         #1;
      end
      fill_en = 1'b0;
      ref_rd  = 32'd0;

      for (int i = 0; i < 14; i++) begin
         run_req($sformatf("row%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wd, lat);
         chk($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].rd);
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
         chk($sformatf("tbl%0d_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].err});
      end

      // Back-to-back: re-toggle right on the response; second request must start at once.
      @(negedge clk);
      #1 f0 = flips;
      @(posedge clk);
      #1;
      run_req("b2b_sh", 4'd7, 32'h380, 32'hA5A5C3E1, lat);
      run_req("b2b_lhu", 4'd5, 32'h380, 32'h0, lat);
      repeat (3) @(posedge clk);
      #1 f1 = flips;
      chk("b2b_flips", f1 - f0, 2);

      // Reset in the second ISSUE cycle of a word store.
      req_op = 4'd8; req_addr = 32'h300; req_wdata = 32'h44332211; req_tog = ~req_tog;
      t0 = cyc;
      wbase = wlog.size();
      @(posedge clk);
      #1;
      chk("abort_busy_k0", {31'd0, busy}, 32'd1);
      chk("abort_wr_k0", {31'd0, ram_wr}, 32'd1);
      chk("abort_addr_k0", ram_addr, 32'h300);
      @(posedge clk);
      #1 rst = 1'b1;
      req_tog = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_wr_after_rst", {31'd0, ram_wr}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("abort_toggle", {31'd0, rsp_toggle}, 32'd0);
         chk("abort_busy", {31'd0, busy}, 32'd0);
      end
      chk("abort_nwr", wlog.size() - wbase, 2);
      if (wlog.size() - wbase >= 2) begin
         chk("abort_w0", {wlog[wbase].a[23:0], wlog[wbase].d}, 32'h00030011);
         chk("abort_w1", {wlog[wbase+1].a[23:0], wlog[wbase+1].d}, 32'h00030122);
         chk("abort_w1_cyc", wlog[wbase+1].c, t0 + 2);
      end
      ref_mem[10'h300] = 8'h11;
      ref_mem[10'h301] = 8'h22;
      ref_rd = 32'd0;
      run_req("post_rst_lw", 4'd3, 32'h300, 32'h0, lat);

      for (int i = 0; i < 80; i++) begin
         rop = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) raddr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
         else raddr = 32'($urandom_range(0, MEMSZ - 1));
         run_req($sformatf("rnd%0d", i), rop, raddr, $urandom, lat);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
